// File: rtl/spi_buf_pkg.sv
// spi_buf shared definitions: default geometry and error flag bit positions.
// Watermark interrupts are enabled with `define SPI_BUF_WMARK_EN.
package spi_buf_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF    = 4;

    localparam int ERR_W      = 4;
    localparam int ERR_TX_OVF = 0;
    localparam int ERR_TX_UDF = 1;
    localparam int ERR_RX_OVF = 2;
    localparam int ERR_RX_UDF = 3;

endpackage

// File: rtl/spi_buf_if.sv
// Byte handshake between spi_buf and spi_master.
// slave is the buffer side, master is the spi_master side.
interface spi_buf_if;

    logic       tx_buf_vld;
    logic [7:0] tx_buf_byte;
    logic       tx_buf_req;
    logic       rx_buf_vld;
    logic       rx_buf_req;
    logic [7:0] rx_buf_byte;

    modport master (
        input  tx_buf_vld,
        input  tx_buf_byte,
        input  rx_buf_vld,
        output tx_buf_req,
        output rx_buf_req,
        output rx_buf_byte
    );

    modport slave (
        output tx_buf_vld,
        output tx_buf_byte,
        output rx_buf_vld,
        input  tx_buf_req,
        input  rx_buf_req,
        input  rx_buf_byte
    );

endinterface

// File: rtl/spi_buf_fifo.sv
// Synchronous byte FIFO with level counter, full/empty flags
// and single-cycle overflow/underflow pulses.
module spi_buf_fifo
    import spi_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          udf
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // A pop on a full FIFO frees the slot the same-cycle push uses.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign ovf   = wr_en && !do_wr;
    assign udf   = rd_en && empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_wr, do_rd})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush && !rst)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_buf.sv
// TX/RX byte buffering in front of spi_master, with sticky errors.
// Define SPI_BUF_WMARK_EN to add tx_wmark/rx_wmark level interrupts.
module spi_buf
    import spi_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             err_clr,
    input  logic             tx_wr_en,
    input  logic [7:0]       tx_wr_data,
    output logic             tx_full,
    output logic [AW:0]      tx_level,
    input  logic             rx_rd_en,
    output logic [7:0]       rx_rd_data,
    output logic             rx_empty,
    output logic [AW:0]      rx_level,
`ifdef SPI_BUF_WMARK_EN
    input  logic [AW:0]      tx_wmark,
    input  logic [AW:0]      rx_wmark,
`endif
    output logic [ERR_W-1:0] err_status,
    output logic             tx_irq,
    output logic             rx_irq,
    spi_buf_if.slave         spi
);

    logic       tx_empty;
    logic       tx_ovf;
    logic       tx_udf;
    logic       rx_full;
    logic       rx_ovf;
    logic       rx_udf;
    logic [7:0] rx_head;
    logic [ERR_W-1:0] err_set;

    spi_buf_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (tx_wr_en),
        .wr_data (tx_wr_data),
        .rd_en   (spi.tx_buf_req),
        .rd_data (spi.tx_buf_byte),
        .level   (tx_level),
        .full    (tx_full),
        .empty   (tx_empty),
        .ovf     (tx_ovf),
        .udf     (tx_udf)
    );

    spi_buf_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (spi.rx_buf_req),
        .wr_data (spi.rx_buf_byte),
        .rd_en   (rx_rd_en),
        .rd_data (rx_head),
        .level   (rx_level),
        .full    (rx_full),
        .empty   (rx_empty),
        .ovf     (rx_ovf),
        .udf     (rx_udf)
    );

    assign spi.tx_buf_vld = !tx_empty;
    assign spi.rx_buf_vld = !rx_full;

    always_comb begin
        err_set             = '0;
        err_set[ERR_TX_OVF] = tx_ovf;
        err_set[ERR_TX_UDF] = tx_udf;
        err_set[ERR_RX_OVF] = rx_ovf;
        err_set[ERR_RX_UDF] = rx_udf;
    end

    // A fresh error in the clear cycle still lands in the flags.
    always_ff @(posedge clk) begin
        if (rst)
            err_status <= '0;
        else if (err_clr)
            err_status <= err_set;
        else
            err_status <= err_status | err_set;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rx_rd_data <= 8'h00;
        else if (rx_rd_en && !rx_empty && !flush)
            rx_rd_data <= rx_head;
    end

`ifdef SPI_BUF_WMARK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_irq <= 1'b0;
            rx_irq <= 1'b0;
        end else begin
            tx_irq <= (tx_level <= tx_wmark);
            rx_irq <= (rx_level >= rx_wmark)
                   && (rx_wmark != '0);
        end
    end
`else
    assign tx_irq = 1'b0;
    assign rx_irq = 1'b0;
`endif

endmodule
